// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Raster timing generator for the dot-clock domain. Produces the
//             pixel/line counters, active-video flag, HSYNC/VSYNC, line and
//             frame strobes, a completed-frame counter, and copies of the
//             sync/active signals delayed to line up with pipelined RGB.
//  Ports    : clk_dot        - dot clock
//             reset_n        - asynchronous reset, active low
//             timing_en      - 1 = raster runs, 0 = raster held idle at 0,0
//             x_cnt/y_cnt    - current raster position (12 bits each)
//             vid_active     - position lies inside the visible area
//             hsync/vsync    - undelayed syncs, asserted level H_POL/V_POL
//             line_start     - one-cycle pulse at x_cnt==0
//             frame_start    - one-cycle pulse at x_cnt==0, y_cnt==0
//             frame_cnt      - completed-frame count (16-bit wrap)
//             hsync_dly, vsync_dly, vid_active_dly - PIPE_DLY-cycle copies
//  Revision : 1.0  initial release
// ============================================================================
module vga_timing_gen #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic H_POL    = 1'b0,
   parameter logic V_POL    = 1'b0,
   parameter int   PIPE_DLY = 3
) (
   input  logic        clk_dot,
   input  logic        reset_n,
   input  logic        timing_en,
   output logic [11:0] x_cnt,
   output logic [11:0] y_cnt,
   output logic        vid_active,
   output logic        hsync,
   output logic        vsync,
   output logic        line_start,
   output logic        frame_start,
   output logic [15:0] frame_cnt,
   output logic        hsync_dly,
   output logic        vsync_dly,
   output logic        vid_active_dly
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // 13-bit boundaries so a 4096-dot total does not alias to zero.
   localparam logic [12:0] H_LAST     = 13'(H_TOTAL - 1);
   localparam logic [12:0] H_ACT_END  = 13'(H_ACTIVE);
   localparam logic [12:0] HS_START   = 13'(H_ACTIVE + H_FP);
   localparam logic [12:0] HS_END     = 13'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [12:0] V_LAST     = 13'(V_TOTAL - 1);
   localparam logic [12:0] V_ACT_END  = 13'(V_ACTIVE);
   localparam logic [12:0] VS_START   = 13'(V_ACTIVE + V_FP);
   localparam logic [12:0] VS_END     = 13'(V_ACTIVE + V_FP + V_SYNC);

   // Elaboration-time legality checks.
   if (H_TOTAL > 4096 || V_TOTAL > 4096 || H_TOTAL < 1 || V_TOTAL < 1) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL/V_TOTAL must be in 1..4096");
   end
   if (PIPE_DLY < 0 || PIPE_DLY > 15) begin : g_bad_dly
      $error("vga_timing_gen: PIPE_DLY must be in 0..15");
   end

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [11:0] x_q, x_d;
   logic [11:0] y_q, y_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   // run_q marks that the previous cycle was enabled; the first enabled
   // cycle after idle/reset presents 0,0 instead of advancing past it.
   logic        run_q, run_d;
   logic        vid_q, vid_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        ls_q, ls_d;
   logic        fs_q, fs_d;

   logic [12:0] x13_d;
   logic [12:0] y13_d;

   // ------------------------------------------------------------------------
   // Next-state counters
   // ------------------------------------------------------------------------
   always_comb begin
      x_d         = x_q;
      y_d         = y_q;
      frame_cnt_d = frame_cnt_q;
      run_d       = run_q;
      if (!timing_en) begin
         x_d   = '0;
         y_d   = '0;
         run_d = 1'b0;
      end else if (!run_q) begin
         x_d   = '0;
         y_d   = '0;
         run_d = 1'b1;
      end else if ({1'b0, x_q} == H_LAST) begin
         x_d = '0;
         if ({1'b0, y_q} == V_LAST) begin
            y_d         = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
         end else begin
            y_d = y_q + 12'd1;
         end
      end else begin
         x_d = x_q + 12'd1;
      end
   end

   // ------------------------------------------------------------------------
   // Decode from next-state position so flags align with the counters
   // ------------------------------------------------------------------------
   always_comb begin
      x13_d   = {1'b0, x_d};
      y13_d   = {1'b0, y_d};
      vid_d   = timing_en && (x13_d < H_ACT_END) && (y13_d < V_ACT_END);
      hsync_d = (timing_en && (x13_d >= HS_START) && (x13_d < HS_END)) ? H_POL : ~H_POL;
      vsync_d = (timing_en && (y13_d >= VS_START) && (y13_d < VS_END)) ? V_POL : ~V_POL;
      ls_d    = timing_en && (x_d == 12'd0);
      fs_d    = timing_en && (x_d == 12'd0) && (y_d == 12'd0);
   end

   always_ff @(posedge clk_dot or negedge reset_n) begin
      if (!reset_n) begin
         x_q         <= '0;
         y_q         <= '0;
         frame_cnt_q <= '0;
         run_q       <= 1'b0;
         vid_q       <= 1'b0;
         hsync_q     <= ~H_POL;
         vsync_q     <= ~V_POL;
         ls_q        <= 1'b0;
         fs_q        <= 1'b0;
      end else begin
         x_q         <= x_d;
         y_q         <= y_d;
         frame_cnt_q <= frame_cnt_d;
         run_q       <= run_d;
         vid_q       <= vid_d;
         hsync_q     <= hsync_d;
         vsync_q     <= vsync_d;
         ls_q        <= ls_d;
         fs_q        <= fs_d;
      end
   end

   assign x_cnt       = x_q;
   assign y_cnt       = y_q;
   assign frame_cnt   = frame_cnt_q;
   assign vid_active  = vid_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign line_start  = ls_q;
   assign frame_start = fs_q;

   // ------------------------------------------------------------------------
   // Delay lines: {hsync, vsync, vid_active} shifted every cycle, including
   // while disabled, so the delayed copies drain to inactive.
   // ------------------------------------------------------------------------
   if (PIPE_DLY == 0) begin : g_dly_none
      assign hsync_dly      = hsync_q;
      assign vsync_dly      = vsync_q;
      assign vid_active_dly = vid_q;
   end else begin : g_dly_pipe
      logic [2:0] dly_q [PIPE_DLY];

      always_ff @(posedge clk_dot or negedge reset_n) begin
         if (!reset_n) begin
            for (int i = 0; i < PIPE_DLY; i++) begin
               dly_q[i] <= {~H_POL, ~V_POL, 1'b0};
            end
         end else begin
            dly_q[0] <= {hsync_q, vsync_q, vid_q};
            for (int i = 1; i < PIPE_DLY; i++) begin
               dly_q[i] <= dly_q[i-1];
            end
         end
      end

      assign hsync_dly      = dly_q[PIPE_DLY-1][2];
      assign vsync_dly      = dly_q[PIPE_DLY-1][1];
      assign vid_active_dly = dly_q[PIPE_DLY-1][0];
   end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator for the dot-clock domain; directly upstream of the sprite and text layers.
- Produces x_cnt/y_cnt, vid_active, and HSYNC/VSYNC from parameterised porch/sync widths.
- Also provides copies of the sync and active signals delayed by a parameterised number of cycles, so syncs arrive at the VGA pins aligned with the pipelined RGB from downstream layers.
- Provides a frame counter and frame/line strobes for software and layer logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (dots)
- H_SYNC, 96, HSYNC width (dots)
- H_BP, 48, horizontal back porch (dots)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, VSYNC width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, HSYNC asserted level
- V_POL, 0, VSYNC asserted level
- PIPE_DLY, 3, delay in cycles for the _dly outputs; legal range 0..15

Ports:
- clk_dot  in  1  dot clock
- reset_n  in  1  asynchronous reset, active low
- timing_en  in  1  1 = raster runs; 0 = raster held idle
- x_cnt  out  12  horizontal position, 0..H_TOTAL-1
- y_cnt  out  12  vertical position, 0..V_TOTAL-1
- vid_active  out  1  x_cnt<H_ACTIVE and y_cnt<V_ACTIVE
- hsync  out  1  horizontal sync, undelayed
- vsync  out  1  vertical sync, undelayed
- line_start  out  1  one-cycle pulse when x_cnt==0
- frame_start  out  1  one-cycle pulse when x_cnt==0 and y_cnt==0
- frame_cnt  out  16  completed-frame count, wraps
- hsync_dly  out  1  hsync delayed PIPE_DLY cycles
- vsync_dly  out  1  vsync delayed PIPE_DLY cycles
- vid_active_dly  out  1  vid_active delayed PIPE_DLY cycles

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Both must be ≤ 4096; this is a static check at elaboration.
- Reset values:
  - x_cnt = 0, y_cnt = 0
  - vid_active = 0, line_start = 0, frame_start = 0
  - frame_cnt = 0
  - hsync = hsync_dly = ~H_POL; vsync = vsync_dly = ~V_POL
  - vid_active_dly = 0; all delay-line stages hold the inactive level
- All outputs are registered. vid_active, hsync, vsync, line_start and frame_start are decoded from the next-state counter values, so they are valid in the same cycle as the x_cnt/y_cnt they describe.
- Counting, when timing_en=1:
  - x_cnt increments every clk_dot.
  - At x_cnt==H_TOTAL-1: x_cnt←0, y_cnt increments.
  - At y_cnt==V_TOTAL-1 on that same wrap: y_cnt←0 and frame_cnt increments (16-bit wrap, 0xFFFF→0).
  - y_cnt changes exactly once per line, on the x wrap. Downstream logic detects line change by comparing y_cnt to its registered copy.
- HSYNC asserted (=H_POL) for H_ACTIVE+H_FP ≤ x_cnt < H_ACTIVE+H_FP+H_SYNC.
- VSYNC asserted (=V_POL) for V_ACTIVE+V_FP ≤ y_cnt < V_ACTIVE+V_FP+V_SYNC, over whole lines (changes only at x_cnt==0).
- frame_start and line_start are pulses in the cycle where the respective counter position is presented.
- timing_en=0:
  - Next cycle x_cnt←0 and y_cnt←0; vid_active=0; syncs inactive; no strobes; frame_cnt holds.
  - The delay lines keep shifting, so the _dly outputs drain to inactive after PIPE_DLY cycles.
  - On re-enable, the first enabled cycle presents x=0,y=0 with frame_start=1. Because y_cnt stays 0 for a full line, downstream line-0 clears fire.
- Delay lines:
  - PIPE_DLY-stage shift registers clocked every cycle.
  - PIPE_DLY=0: _dly outputs equal the undelayed outputs.
  - Default 3 matches the 3-cycle x_cnt→rgb latency of the sprite layer.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronous). After release, counting restarts at 0,0 with frame_start on the first enabled edge; there is no partial-line behaviour.

Test Plan:
Small configuration for all scenarios unless stated: H=8/2/3/3 (H_TOTAL 16), V=4/1/2/1 (V_TOTAL 8), PIPE_DLY=3, polarities 0.
- Reset then enable → x_cnt sequence 0..15,0; y_cnt increments 0→1 in the same cycle x returns to 0; frame_start=1 only at (0,0); line_start every 16 cycles.
- vid_active and syncs → vid_active=1 exactly for x 0..7 on y 0..3, i.e. 32 cycles per frame; hsync=0 for x 10..12 only; vsync=0 for y 5..6 on all 16 dots of each of those lines.
- Frame counter → after 128 cycles frame_cnt=1. Force frame_cnt near 0xFFFF via run length → 0xFFFF wraps to 0x0000.
- Delay alignment → hsync_dly equals hsync shifted exactly 3 cycles; repeat with PIPE_DLY=0 → identical to hsync.
- timing_en dropped at x=5,y=2 → next cycle x=y=0, syncs high; _dly outputs return to inactive 3 cycles later; re-enable → frame_start pulse, frame_cnt unchanged.
- reset_n pulsed low mid-line at x=9,y=6 → outputs at reset values without waiting for a clock edge; after release counting restarts at (0,0).
